// File: rtl/event_buffer_pkg.sv
// Shared definitions for the event buffer read side: header layout, event
// counter width and the reader FSM states.
package event_buffer_pkg;

  localparam logic [3:0] HDR_MAGIC     = 4'hE;
  localparam int         HDR_MAGIC_LSB = 28;
  localparam int         HDR_CNT_LSB   = 16;
  localparam int         EVT_CNT_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_READ,
    ST_DRAIN,
    ST_DONE,
    ST_HOLD
  } state_e;

  // buf_field is the zero-extended buffer index occupying bits [15:0].
  function automatic logic [31:0] make_header(input logic [EVT_CNT_W-1:0] cnt,
                                              input logic [15:0] buf_field);
    logic [31:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: 4]       = HDR_MAGIC;
    hdr[HDR_CNT_LSB +: EVT_CNT_W] = cnt;
    hdr[HDR_CNT_LSB-1:0]          = buf_field;
    return hdr;
  endfunction

endpackage

// File: rtl/event_stream_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible on dout
// whenever empty is low, and dout reads zero while empty.
module event_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/event_buffer_reader.sv
// Sweeps a pending event buffer across all channel RAMs and emits it as a
// framed 32-bit stream; issue is credit-limited so RAM read latency never overflows the FIFO.
module event_buffer_reader
  import event_buffer_pkg::*;
#(
  parameter int NCHAN      = 8,
  parameter int NBUF_BITS  = 3,
  parameter int NADDR_BITS = 10,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            ifclk_i,
  input  logic                            ifclk_rst_i,
  input  logic                            evt_pending_i,
  input  logic [NBUF_BITS-1:0]            evt_buffer_i,
  output logic                            evt_done_o,
  output logic                            rd_en_o,
  output logic [NBUF_BITS+NADDR_BITS-1:0] rd_addr_o,
  input  logic [32*NCHAN-1:0]             rd_dat_i,
  output logic [31:0]                     m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH+1);
  localparam int IFW  = $clog2(RD_LATENCY+1);
  localparam int CRW  = $clog2(FIFO_DEPTH+RD_LATENCY+1) + 1;

  state_e                 state_q, state_d;
  logic [NBUF_BITS-1:0]   buf_q;
  logic [CHW-1:0]         ch_q;
  logic [NADDR_BITS-1:0]  addr_q;
  logic [EVT_CNT_W-1:0]   evt_cnt_q;
  logic                   tlast_seen_q;

  logic [RD_LATENCY-1:0]  vld_p;
  logic [RD_LATENCY-1:0]  last_p;
  logic [CHW-1:0]         ch_p [RD_LATENCY];

  logic [IFW-1:0]         in_flight;
  logic signed [CRW-1:0]  credit;
  logic                   issue, hdr_push, latch_evt, last_rd, stream_hs;
  logic                   fifo_push, fifo_full, fifo_empty;
  logic [CNTW-1:0]        fifo_count;
  logic [32:0]            fifo_din, fifo_dout;
  logic [31:0]            exit_dat;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + IFW'(vld_p[i]);
  end

  // Words already in the FIFO plus reads still in the RAM pipeline must fit.
  assign credit    = CRW'(FIFO_DEPTH) - CRW'(fifo_count) - CRW'(in_flight);
  assign last_rd   = (ch_q == CHW'(NCHAN-1)) && (addr_q == '1);
  assign stream_hs = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    hdr_push   = 1'b0;
    latch_evt  = 1'b0;
    evt_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (evt_pending_i) begin
          latch_evt = 1'b1;
          state_d   = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (!fifo_full) begin
          hdr_push = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (credit > 0) begin
          issue = 1'b1;
          if (last_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((in_flight == '0) && fifo_empty && tlast_seen_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        evt_done_o = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ifclk_i or posedge ifclk_rst_i) begin
    if (ifclk_rst_i) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      ch_q         <= '0;
      addr_q       <= '0;
      evt_cnt_q    <= '0;
      tlast_seen_q <= 1'b0;
      vld_p        <= '0;
    end else begin
      state_q <= state_d;
      if (latch_evt) begin
        buf_q        <= evt_buffer_i;
        ch_q         <= '0;
        addr_q       <= '0;
        tlast_seen_q <= 1'b0;
      end else if (issue) begin
        addr_q <= addr_q + 1'b1;
        if (addr_q == '1) ch_q <= ch_q + 1'b1;
      end
      if (stream_hs && m_axis_tlast) tlast_seen_q <= 1'b1;
      if (state_q == ST_DONE) evt_cnt_q <= evt_cnt_q + 1'b1;
      vld_p[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Read pipeline: channel and last-word tag follow each read through the RAM latency.
  always_ff @(posedge ifclk_i) begin
    ch_p[0]   <= ch_q;
    last_p[0] <= last_rd;
    for (int i = 1; i < RD_LATENCY; i++) begin
      ch_p[i]   <= ch_p[i-1];
      last_p[i] <= last_p[i-1];
    end
  end

  always_comb begin
    exit_dat = '0;
    for (int c = 0; c < NCHAN; c++)
      if (ch_p[RD_LATENCY-1] == CHW'(c)) exit_dat = rd_dat_i[32*c +: 32];
  end

  assign fifo_push = hdr_push || vld_p[RD_LATENCY-1];
  assign fifo_din  = hdr_push ? {1'b0, make_header(evt_cnt_q, 16'(buf_q))}
                              : {last_p[RD_LATENCY-1], exit_dat};

  event_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk   (ifclk_i),
    .rst   (ifclk_rst_i),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (stream_hs),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rd_en_o       = issue;
  assign rd_addr_o     = issue ? {buf_q, addr_q} : '0;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_dout[31:0];
  assign m_axis_tlast  = fifo_dout[32];

endmodule

// File: tb/tb_event_buffer_reader.sv
// Directed bench for event_buffer_reader with a 2-cycle RAM model and a small
// 4-address-per-channel configuration (33 words per event).
module tb_event_buffer_reader;
  import event_buffer_pkg::*;

  localparam int NCHAN      = 8;
  localparam int NBUF_BITS  = 3;
  localparam int NADDR_BITS = 2;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int NWORDS     = 1 + NCHAN * (1 << NADDR_BITS);

  logic                            clk = 1'b0;
  logic                            rst = 1'b1;
  logic                            evt_pending = 1'b0;
  logic [NBUF_BITS-1:0]            evt_buffer = '0;
  logic                            evt_done;
  logic                            rd_en;
  logic [NBUF_BITS+NADDR_BITS-1:0] rd_addr;
  logic [32*NCHAN-1:0]             rd_dat;
  logic [31:0]                     tdata;
  logic                            tvalid;
  logic                            tready = 1'b1;
  logic                            tlast;

  event_buffer_reader #(
    .NCHAN      (NCHAN),
    .NBUF_BITS  (NBUF_BITS),
    .NADDR_BITS (NADDR_BITS),
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .ifclk_i       (clk),
    .ifclk_rst_i   (rst),
    .evt_pending_i (evt_pending),
    .evt_buffer_i  (evt_buffer),
    .evt_done_o    (evt_done),
    .rd_en_o       (rd_en),
    .rd_addr_o     (rd_addr),
    .rd_dat_i      (rd_dat),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  // RAM model: address registered twice, data = {A5, channel, address}.
  logic [NADDR_BITS-1:0] a_p1, a_p2;
  always @(posedge clk) begin
    a_p1 <= rd_addr[NADDR_BITS-1:0];
    a_p2 <= a_p1;
  end
  always_comb begin
    rd_dat = '0;
    for (int c = 0; c < NCHAN; c++) rd_dat[32*c +: 32] = {8'hA5, 8'(c), 16'(a_p2)};
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [32:0] cap_q [$];
  int          cap_t [$];
  int          done_t [$];
  int          n_done  = 0;
  int          sample  = 0;
  int          max_occ = 0;

  // Observe 1 time unit before each rising edge, where handshakes are decided.
  always @(negedge clk) begin
    int occ;
    #4;
    sample++;
    if (tvalid && tready) begin
      cap_q.push_back({tlast, tdata});
      cap_t.push_back(sample);
    end
    if (evt_done) begin
      n_done++;
      done_t.push_back(sample);
    end
    occ = int'(dut.in_flight) + int'(dut.fifo_count);
    if (occ > max_occ) max_occ = occ;
  end

  function automatic logic [32:0] exp_word(input int k, input int cnt, input int b);
    logic [32:0] w;
    int j;
    if (k == 0) begin
      w = {1'b0, 4'hE, 12'(cnt), 13'd0, 3'(b)};
    end else begin
      j = k - 1;
      w = {(k == NWORDS-1), 8'hA5, 8'(j / (1 << NADDR_BITS)), 16'(j % (1 << NADDR_BITS))};
    end
    return w;
  endfunction

  task automatic clear_capture();
    cap_q.delete();
    cap_t.delete();
    done_t.delete();
  endtask

  task automatic start_event(input int b);
    @(negedge clk);
    evt_pending = 1'b1;
    evt_buffer  = 3'(b);
    @(negedge clk);
    evt_pending = 1'b0;
  endtask

  task automatic run_until_done(input int target, input int budget, input bit rand_ready,
                                output bit ok);
    int cyc;
    cyc = 0;
    while (n_done < target && cyc < budget) begin
      @(negedge clk);
      tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    tready = 1'b1;
    ok = (n_done >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tvalid, tdata, tlast, rd_en, rd_addr, evt_done} !== '0)
      $display("FAIL reset_outputs: got %h required 0",
               {tvalid, tdata, tlast, rd_en, rd_addr, evt_done});
    else n_pass++;
    n_checks++;
    if (dut.state_q !== ST_IDLE || dut.fifo_count !== '0 || dut.evt_cnt_q !== '0)
      $display("FAIL reset_state: state %0d count %0d evt_cnt %0d required 0/0/0",
               dut.state_q, dut.fifo_count, dut.evt_cnt_q);
    else n_pass++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tvalid !== 1'b0 || dut.state_q !== ST_IDLE)
      $display("FAIL idle_quiet: tvalid %b state %0d required 0/IDLE", tvalid, dut.state_q);
    else n_pass++;
  endtask

  task automatic test_single_event();
    bit ok;
    int base, errs, bad, nlast;
    clear_capture();
    base   = n_done;
    tready = 1'b1;
    @(negedge clk);
    evt_pending = 1'b1;
    evt_buffer  = 3'd3;
    #4;
    n_checks++;
    if (tvalid !== 1'b0) $display("FAIL hdr_early_n: tvalid %b required 0", tvalid);
    else n_pass++;
    @(negedge clk);
    evt_pending = 1'b0;
    #4;
    n_checks++;
    if (tvalid !== 1'b0) $display("FAIL hdr_early_n1: tvalid %b required 0", tvalid);
    else n_pass++;
    @(negedge clk);
    #4;
    n_checks++;
    if (tvalid !== 1'b1 || tdata !== 32'hE000_0003)
      $display("FAIL hdr_latency: tvalid %b tdata %h required 1 e0000003", tvalid, tdata);
    else n_pass++;
    run_until_done(base + 1, 400, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL s1_done_timeout: done count %0d required %0d", n_done, base + 1);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_done !== base + 1) $display("FAIL s1_one_done: got %0d required %0d", n_done - base, 1);
    else n_pass++;
    n_checks++;
    if (cap_q.size() !== NWORDS) $display("FAIL s1_count: got %0d required %0d", cap_q.size(), NWORDS);
    else n_pass++;
    if (cap_q.size() == NWORDS) begin
      n_checks++;
      if (cap_q[1] !== {1'b0, 32'hA500_0000}) $display("FAIL s1_word1: got %h required 0a5000000", cap_q[1]);
      else n_pass++;
      n_checks++;
      if (cap_q[NWORDS-1] !== {1'b1, 32'hA507_0003})
        $display("FAIL s1_last: got %h required 1a5070003", cap_q[NWORDS-1]);
      else n_pass++;
      errs = 0; bad = 0; nlast = 0;
      for (int k = 0; k < NWORDS; k++) begin
        nlast += int'(cap_q[k][32]);
        if (cap_q[k] !== exp_word(k, 0, 3)) begin
          if (errs == 0) bad = k;
          errs++;
        end
      end
      n_checks++;
      if (errs != 0 || nlast != 1)
        $display("FAIL s1_sequence: %0d bad words, %0d tlast, first bad %0d got %h required %h",
                 errs, nlast, bad, cap_q[bad], exp_word(bad, 0, 3));
      else n_pass++;
      n_checks++;
      if (done_t.size() < 1 || done_t[0] <= cap_t[NWORDS-1])
        $display("FAIL s1_done_after_tlast: done sample %0d tlast sample %0d",
                 (done_t.size() > 0) ? done_t[0] : -1, cap_t[NWORDS-1]);
      else n_pass++;
    end
  endtask

  task automatic test_random_ready();
    bit ok;
    int base, errs, bad;
    clear_capture();
    base    = n_done;
    max_occ = 0;
    start_event(3);
    run_until_done(base + 1, 1000, 1'b1, ok);
    n_checks++;
    if (!ok) $display("FAIL s2_done_timeout: done count %0d required %0d", n_done, base + 1);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cap_q.size() !== NWORDS) $display("FAIL s2_count: got %0d required %0d", cap_q.size(), NWORDS);
    else n_pass++;
    if (cap_q.size() == NWORDS) begin
      errs = 0; bad = 0;
      for (int k = 0; k < NWORDS; k++)
        if (cap_q[k] !== exp_word(k, 1, 3)) begin
          if (errs == 0) bad = k;
          errs++;
        end
      n_checks++;
      if (errs != 0)
        $display("FAIL s2_sequence: %0d bad words, first %0d got %h required %h",
                 errs, bad, cap_q[bad], exp_word(bad, 1, 3));
      else n_pass++;
    end
    n_checks++;
    if (max_occ > FIFO_DEPTH) $display("FAIL s2_occupancy: got %0d required <= %0d", max_occ, FIFO_DEPTH);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    int base, cyc, unstable, rd_cnt, errs, bad;
    logic [32:0] hold;
    clear_capture();
    base = n_done;
    start_event(6);
    cyc = 0;
    while (cap_q.size() < 8 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cap_q.size() < 8) $display("FAIL s4_start_timeout: got %0d words required 8", cap_q.size());
    else n_pass++;
    @(negedge clk);
    tready = 1'b0;
    #4;
    hold = {tlast, tdata};
    n_checks++;
    if (tvalid !== 1'b1) $display("FAIL s4_valid_held: tvalid %b required 1", tvalid);
    else n_pass++;
    unstable = 0;
    rd_cnt   = int'(rd_en);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #4;
      if (!tvalid || {tlast, tdata} !== hold) unstable++;
      rd_cnt += int'(rd_en);
    end
    n_checks++;
    if (unstable != 0) $display("FAIL s4_stable: %0d changed samples required 0 (held %h)", unstable, hold);
    else n_pass++;
    n_checks++;
    if (rd_cnt > FIFO_DEPTH || rd_en !== 1'b0)
      $display("FAIL s4_issue_stop: %0d reads during stall, rd_en %b required <= 4 and 0", rd_cnt, rd_en);
    else n_pass++;
    run_until_done(base + 1, 400, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL s4_done_timeout: done count %0d required %0d", n_done, base + 1);
    else n_pass++;
    errs = 0; bad = 0;
    if (cap_q.size() != NWORDS) errs = 1;
    else
      for (int k = 0; k < NWORDS; k++)
        if (cap_q[k] !== exp_word(k, 2, 6)) begin
          if (errs == 0) bad = k;
          errs++;
        end
    n_checks++;
    if (errs != 0)
      $display("FAIL s4_sequence: %0d words captured, %0d bad, first bad %0d required %h",
               cap_q.size(), errs, bad, exp_word(bad, 2, 6));
    else n_pass++;
  endtask

  task automatic test_reset_mid_event();
    bit ok;
    int cyc, dn, errs, bad;
    clear_capture();
    start_event(2);
    cyc = 0;
    while (!(dut.state_q == ST_READ && cap_q.size() >= 4) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (dut.state_q !== ST_READ) $display("FAIL s5_reach_read: state %0d required READ", dut.state_q);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({tvalid, tdata, tlast, rd_en, rd_addr, evt_done} !== '0)
      $display("FAIL s5_reset_outputs: got %h required 0",
               {tvalid, tdata, tlast, rd_en, rd_addr, evt_done});
    else n_pass++;
    dn = n_done;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (n_done !== dn) $display("FAIL s5_no_done: got %0d pulses required 0", n_done - dn);
    else n_pass++;
    clear_capture();
    start_event(4);
    run_until_done(dn + 1, 400, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL s5_done_timeout: done count %0d required %0d", n_done, dn + 1);
    else n_pass++;
    errs = 0; bad = 0;
    if (cap_q.size() != NWORDS) errs = 1;
    else
      for (int k = 0; k < NWORDS; k++)
        if (cap_q[k] !== exp_word(k, 0, 4)) begin
          if (errs == 0) bad = k;
          errs++;
        end
    n_checks++;
    if (errs != 0)
      $display("FAIL s5_restart_sequence: %0d words, %0d bad, first bad %0d required %h",
               cap_q.size(), errs, bad, exp_word(bad, 0, 4));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base, errs, bad;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_capture();
    base = n_done;
    @(negedge clk);
    evt_pending = 1'b1;
    evt_buffer  = 3'd3;
    run_until_done(base + 1, 400, 1'b0, ok);
    n_checks++;
    if (!ok || dut.state_q !== ST_HOLD)
      $display("FAIL s3_hold_cycle: done %b state %0d required HOLD", ok, dut.state_q);
    else n_pass++;
    evt_buffer = 3'd5;
    @(negedge clk);
    @(negedge clk);
    evt_pending = 1'b0;
    run_until_done(base + 2, 400, 1'b0, ok);
    n_checks++;
    if (!ok) $display("FAIL s3_done_timeout: done count %0d required %0d", n_done - base, 2);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_done !== base + 2) $display("FAIL s3_two_done: got %0d required 2", n_done - base);
    else n_pass++;
    n_checks++;
    if (cap_q.size() !== 2*NWORDS) $display("FAIL s3_count: got %0d required %0d", cap_q.size(), 2*NWORDS);
    else n_pass++;
    if (cap_q.size() == 2*NWORDS) begin
      n_checks++;
      if (cap_q[NWORDS][31:0] !== 32'hE001_0005)
        $display("FAIL s3_header2: got %h required e0010005", cap_q[NWORDS][31:0]);
      else n_pass++;
      errs = 0; bad = 0;
      for (int k = 0; k < 2*NWORDS; k++)
        if (cap_q[k] !== ((k < NWORDS) ? exp_word(k, 0, 3) : exp_word(k - NWORDS, 1, 5))) begin
          if (errs == 0) bad = k;
          errs++;
        end
      n_checks++;
      if (errs != 0) $display("FAIL s3_sequence: %0d bad words, first %0d got %h", errs, bad, cap_q[bad]);
      else n_pass++;
      n_checks++;
      if (done_t.size() < 1 || done_t[0] >= cap_t[NWORDS])
        $display("FAIL s3_order: first done sample %0d second header sample %0d",
                 (done_t.size() > 0) ? done_t[0] : -1, cap_t[NWORDS]);
      else n_pass++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_event();
    test_random_ready();
    test_stall();
    test_reset_mid_event();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
